// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer: shift-add multiplier and restoring divider.
// Optional macro MDU_ZERO_SKIP_EN: zero-operand requests bypass PREP/RUN and go straight to FIX.

module mdu_seq_ctrl #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [2:0]  OP_MUL = 3'b010,
  parameter logic [2:0]  OP_DIV = 3'b011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       aluCtrl,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic             div_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_is_div;
  logic [WIDTH-1:0] r_src1;
  logic [WIDTH-1:0] r_src2;
  logic             r_neg_a;
  logic             r_neg_b;
  logic [WIDTH-1:0] r_mcand;
  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;

  logic             w_req;
  logic             w_skip;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rmd;

  assign w_req = start && ((aluCtrl == OP_MUL) || (aluCtrl == OP_DIV));

`ifdef MDU_ZERO_SKIP_EN
  assign w_skip = (src2 == '0) || ((src1 == '0) && (aluCtrl == OP_MUL));
`else
  assign w_skip = 1'b0;
`endif

  // Unsigned magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits.
  assign w_mag1 = r_src1[WIDTH-1] ? -r_src1 : r_src1;
  assign w_mag2 = r_src2[WIDTH-1] ? -r_src2 : r_src2;

  // Multiply step: conditionally add multiplicand into the high half, then shift right.
  assign w_add = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

  // Divide step: shift next dividend bit into the partial remainder and trial-subtract.
  assign w_shift   = {r_rem, r_acc[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_mcand});
  assign w_diff    = WIDTH'(w_shift - {1'b0, r_mcand});
  assign w_rem_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];

  assign w_prod = r_neg_a ? -r_acc : r_acc;
  assign w_quo  = r_neg_a ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rmd  = r_neg_b ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_a    <= '0;
      res_b    <= '0;
      div_zero <= 1'b0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (w_req) begin
            r_src1   <= src1;
            r_src2   <= src2;
            r_is_div <= (aluCtrl == OP_DIV);
            div_zero <= 1'b0;
            busy     <= 1'b1;
            // Zeroed datapath doubles as the zero result on the skip path.
            r_acc    <= '0;
            r_rem    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_state  <= w_skip ? S_FIX : S_PREP;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_PREP: begin
          r_neg_a <= r_src1[WIDTH-1] ^ r_src2[WIDTH-1];
          r_neg_b <= r_is_div & r_src1[WIDTH-1];
          r_mcand <= r_is_div ? w_mag2 : w_mag1;
          r_acc   <= {{WIDTH{1'b0}}, (r_is_div ? w_mag1 : w_mag2)};
          r_rem   <= '0;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end

        S_RUN: begin
          if (r_is_div) begin
            r_rem             <= w_rem_nxt;
            r_acc[WIDTH-1:0]  <= {r_acc[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= {w_add, r_acc[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          if (r_is_div) begin
            if (r_src2 == '0) begin
              res_a    <= '1;
              res_b    <= r_src1;
              div_zero <= 1'b1;
            end else begin
              res_a <= w_quo;
              res_b <= w_rmd;
            end
          end else begin
            res_a <= w_prod[W2-1:WIDTH];
            res_b <= w_prod[WIDTH-1:0];
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Scoreboard bench for mdu_seq_ctrl: directed plan cases plus randomized back-to-back traffic.

module tb_mdu_seq_ctrl;

  localparam int unsigned W      = 32;
  localparam logic [2:0]  OP_MUL = 3'b010;
  localparam logic [2:0]  OP_DIV = 3'b011;
  localparam int          LAT    = W + 3;
`ifdef MDU_ZERO_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   aluCtrl;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         busy;
  logic         done;
  logic [W-1:0] res_a;
  logic [W-1:0] res_b;
  logic         div_zero;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;
  int r_free = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         dz;
    int           s;
    int           d;
  } exp_t;

  exp_t sb_q[$];

  mdu_seq_ctrl #(.WIDTH(W), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .aluCtrl  (aluCtrl),
    .src1     (src1),
    .src2     (src2),
    .busy     (busy),
    .done     (done),
    .res_a    (res_a),
    .res_b    (res_b),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed 64-bit arithmetic; / and % truncate toward zero with dividend-signed remainder.
  function automatic logic [2*W:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p, qq, rr;
    logic [63:0] pu;
    sa = $signed(a);
    sb = $signed(b);
    if (op == OP_MUL) begin
      p  = sa * sb;
      pu = p;
      return {1'b0, pu};
    end
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    qq = sa / sb;
    rr = sa % sb;
    pu = {qq[W-1:0], rr[W-1:0]};
    return {1'b0, pu};
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (SKIP_EN && ((b == '0) || ((a == '0) && (op == OP_MUL)))) return 2;
    return LAT;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    case ($urandom_range(0, 7))
      0:       r = '0;
      1:       r = W'(1);
      2:       r = '1;
      3:       r = 32'h8000_0000;
      4:       r = 32'h7FFF_FFFF;
      5:       r = W'($urandom_range(0, 50));
      6:       r = -W'($urandom_range(1, 50));
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // Issue one request as soon as the previous one reaches DONE; record what must come back.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ea, input logic [W-1:0] eb, input logic edz);
    exp_t e;
    while (cyc < r_free) tick();
    start   = 1'b1;
    aluCtrl = op;
    src1    = a;
    src2    = b;
    tick();
    start   = 1'b0;
    src1    = $urandom;
    src2    = $urandom;
    aluCtrl = 3'($urandom);
    e.a  = ea;
    e.b  = eb;
    e.dz = edz;
    e.s  = cyc;
    e.d  = cyc + lat_of(op, a, b) - 1;
    sb_q.push_back(e);
    r_free = e.d;
  endtask

  task automatic issue_m(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W:0] m;
    m = model(op, a, b);
    issue(op, a, b, m[2*W-1:W], m[W-1:0], m[2*W]);
  endtask

  // Monitor: busy tracks the in-flight request; every done pulse pops and checks the scoreboard.
  always @(negedge clk) begin
    logic b_exp;
    exp_t e;
    if (mon_en) begin
      b_exp = (sb_q.size() > 0) && (cyc >= sb_q[0].s) && (cyc < sb_q[0].d);
      chk("busy", W'(busy), W'(b_exp));
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done: unexpected pulse @cyc %0d", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("latency", W'(cyc), W'(e.d));
          chk("res_a", res_a, e.a);
          chk("res_b", res_b, e.b);
          chk("div_zero", W'(div_zero), W'(e.dz));
        end
      end else if ((sb_q.size() > 0) && (cyc >= sb_q[0].d)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done: missing pulse @cyc %0d, due %0d", cyc, sb_q[0].d);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    int           s, k;

    reset   = 1'b1;
    start   = 1'b0;
    aluCtrl = '0;
    src1    = '0;
    src2    = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_res_a", res_a, '0);
    chk("rst_res_b", res_b, '0);
    chk("rst_div_zero", W'(div_zero), '0);
    mon_en = 1'b1;
    r_free = cyc;

    issue(OP_MUL, 32'd7, 32'd2, 32'h0000_0000, 32'h0000_000E, 1'b0);
    issue(OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    issue(OP_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'h0000_0007, 1'b1);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
    issue(OP_MUL, 32'd4, 32'd4, 32'h0000_0000, 32'h0000_0010, 1'b0);
    issue(OP_MUL, 32'd0, 32'h1234, 32'h0, 32'h0, 1'b0);
    issue(OP_MUL, 32'h8000_0000, 32'd0, 32'h0, 32'h0, 1'b0);
    issue(OP_DIV, 32'd0, 32'd5, 32'h0, 32'h0, 1'b0);
    issue(OP_DIV, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue(OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) == 1) ? OP_MUL : OP_DIV;
      a  = rnd();
      b  = rnd();
      if ($urandom_range(0, 3) == 0) r_free += $urandom_range(1, 4);
      issue_m(op, a, b);
      // Occasionally poke start while the unit is still busy; it must be dropped.
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, r_free - 1 - cyc);
        repeat (k) tick();
        start   = 1'b1;
        aluCtrl = ($urandom_range(0, 1) == 1) ? OP_MUL : OP_DIV;
        src1    = $urandom;
        src2    = $urandom;
        tick();
        start   = 1'b0;
      end
    end

    // Leave non-zero results behind so the abort reset visibly clears them.
    issue(OP_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'h0000_0007, 1'b1);
    issue(OP_MUL, 32'd5, 32'd5, 32'h0, 32'd25, 1'b0);
    s = cyc;
    while (cyc < s + 8) tick();
    start   = 1'b1;
    aluCtrl = OP_MUL;
    src1    = 32'd9;
    src2    = 32'd9;
    tick();
    start = 1'b0;
    while (cyc < s + 18) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    r_free = cyc;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_res_a", res_a, '0);
    chk("abort_res_b", res_b, '0);
    chk("abort_div_zero", W'(div_zero), '0);

    start   = 1'b1;
    aluCtrl = 3'b000;
    src1    = 32'd3;
    src2    = 32'd3;
    tick();
    aluCtrl = 3'b111;
    tick();
    start = 1'b0;
    tick();
    chk("nop_busy", W'(busy), '0);
    repeat (40) tick();

    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
    issue_m(OP_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFF0);

    while ((sb_q.size() > 0) && (cyc <= r_free + 2)) tick();
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the MIPS datapath; replaces the single-cycle MUL/DIV paths of the ALU with an iterative shift-add multiplier and restoring divider.
- Driven by the decode stage with the same 3-bit ALU control codes.
- Produces the same result pair: res_a is product-high or quotient; res_b is product-low or remainder.
- Raises busy so the pipeline and PC logic stall until done.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- OP_MUL, 3'b010, control code for multiply.
- OP_DIV, 3'b011, control code for divide.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the FSM is in IDLE or DONE.
- aluCtrl  input  3  operation code; sampled with start.
- src1  input  WIDTH  multiplicand / dividend, two's complement.
- src2  input  WIDTH  multiplier / divisor, two's complement.
- busy  output  1  high in PREP, RUN and FIX states.
- done  output  1  one-cycle pulse; results valid this cycle and afterwards.
- res_a  output  WIDTH  product[2W-1:W] or quotient.
- res_b  output  WIDTH  product[W-1:0] or remainder.
- div_zero  output  1  set at completion of a DIV with src2==0; cleared at the next accepted start.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, res_a=0, res_b=0, div_zero=0; iteration counter=0. Reset mid-operation aborts the operation with no result update.
- Accept: start=1 and aluCtrl in {OP_MUL, OP_DIV} and state in {IDLE, DONE}.
  - Latches operands and op; clears div_zero; goes to PREP.
  - start with any other aluCtrl is ignored; no state change.
  - start while busy=1 is ignored and not queued.
- PREP (1 cycle): record result signs, then convert operands to magnitudes (unsigned WIDTH+1 safe; -2^(W-1) handled).
  - MUL sign = s1^s2.
  - DIV quotient sign = s1^s2; remainder sign = s1.
- RUN (exactly WIDTH cycles, counter 0..WIDTH-1):
  - MUL: shift-add, one multiplier bit per cycle into a 2W accumulator.
  - DIV: restoring division, one quotient bit per cycle, partial remainder W+1 bits.
- FIX (1 cycle): two's-complement negate per recorded signs. MUL negates the full 2W product.
  - DIV by zero overrides the result: res_a={WIDTH{1'b1}}, res_b=src1 as latched (original signed value); div_zero=1.
  - Overflow -2^(W-1) / -1 gives res_a=0x80000000, res_b=0; no flag.
- DONE (1 cycle): done=1, busy=0. res_a and res_b are registered and hold until the next completion.
  - Next state is PREP if a new start is accepted, else IDLE.
- Latency: done asserts in the cycle after WIDTH+3 rising edges, counting from the edge that samples start (35 for WIDTH=32). Latency is fixed regardless of operand values, unless the optional feature below is compiled in.
- Throughput: back-to-back starts are accepted in the DONE cycle, so there are no idle bubbles.
- Division semantics: truncate toward zero; remainder takes the dividend's sign; |rem| < |divisor|.

Optional Feature:
- Macro MDU_ZERO_SKIP_EN. When defined, an accepted start goes directly IDLE/DONE -> FIX if either condition holds:
  - src2==0 (MUL or DIV), or
  - src1==0 with op=MUL.
- On this path PREP and RUN are skipped and done asserts after 2 edges. Results are identical to the full path: MUL gives 0 and 0; DIV-by-zero uses the rule above, with div_zero=1.
- When the macro is undefined, latency is always WIDTH+3.

Test Plan:
- MUL src1=7, src2=2 -> after 35 edges: done=1, res_a=0x00000000, res_b=0x0000000E; busy=1 for the preceding 34 cycles.
- MUL src1=-3 (0xFFFFFFFD), src2=5 -> res_a=0xFFFFFFFF, res_b=0xFFFFFFF1.
- DIV src1=-7, src2=2 -> res_a=0xFFFFFFFD (-3), res_b=0xFFFFFFFF (-1), div_zero=0.
- DIV src1=7, src2=0 -> res_a=0xFFFFFFFF, res_b=0x00000007, div_zero=1.
  - Latency is 35 edges without MDU_ZERO_SKIP_EN and 2 edges with it.
- DIV 0x80000000 / 0xFFFFFFFF -> res_a=0x80000000, res_b=0.
  - Then a second start in the DONE cycle (MUL 4*4) is accepted; its done arrives 35 edges later with res_b=0x10.
- Abort and ignore: start MUL 5*5, pulse start again at edge 10 -> ignored.
  - Assert reset at edge 20 -> next cycle busy=0, done=0, res_a=0, res_b=0; no done pulse follows.
  - start with aluCtrl=3'b000 -> no busy.
